// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: instruction type codes, register-file geometry
// and a popcount helper used by the hazard scoreboard.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [4:0] {
    INSTR_NOOP     = 5'd0,
    INSTR_LOAD_IMM = 5'd1,
    INSTR_LOAD_MEM = 5'd2,
    INSTR_STORE    = 5'd3,
    INSTR_ALU_OP   = 5'd4,
    INSTR_JUMP     = 5'd5
  } instr_type_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight register write scoreboard: set on issue, clear on write-back, three pend lookups
// and a registered popcount. WB_BYPASS_EN hides a same-cycle write-back from the lookups.
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS_P = pipeline_ctrl_pkg::NUM_REGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_en,
  input  logic [4:0]       i_set_reg,
  input  logic             i_clr_en,
  input  logic [4:0]       i_clr_reg,
  input  logic [4:0]       i_rd_reg_0,
  input  logic [4:0]       i_rd_reg_1,
  input  logic [4:0]       i_rd_reg_2,
  output logic             o_pend_0,
  output logic             o_pend_1,
  output logic             o_pend_2,
  output logic             o_clr_hit,
  output logic [CNT_W-1:0] o_pending_count
);

  logic [NUM_REGS_P-1:0] r_board;
  logic [NUM_REGS_P-1:0] w_board_d;
  logic [NUM_REGS_P-1:0] w_clr_mask;
  logic [NUM_REGS_P-1:0] w_pend_vec;
  logic [CNT_W-1:0]      r_pending_count;

  always_comb begin
    w_clr_mask = '0;
    if (i_clr_en) begin
      w_clr_mask[i_clr_reg] = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle issue to the retiring register wins.
  always_comb begin
    w_board_d = r_board & ~w_clr_mask;
    if (i_set_en && (i_set_reg != '0)) begin
      w_board_d[i_set_reg] = 1'b1;
    end
    w_board_d[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  assign w_pend_vec = r_board & ~w_clr_mask;
`else
  assign w_pend_vec = r_board;
`endif

  assign o_pend_0  = (i_rd_reg_0 != '0) && w_pend_vec[i_rd_reg_0];
  assign o_pend_1  = (i_rd_reg_1 != '0) && w_pend_vec[i_rd_reg_1];
  assign o_pend_2  = (i_rd_reg_2 != '0) && w_pend_vec[i_rd_reg_2];
  assign o_clr_hit = r_board[i_clr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_board         <= '0;
      r_pending_count <= '0;
    end else begin
      r_board         <= w_board_d;
      r_pending_count <= popcount(w_board_d);
    end
  end

  assign o_pending_count = r_pending_count;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage stall/squash sequencer: RAW/WAW stall from the scoreboard, multi-cycle squash
// window on taken jumps, sticky spurious write-back flag. Optional macro: WB_BYPASS_EN.
module decode_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter int unsigned NUM_REGS      = pipeline_ctrl_pkg::NUM_REGS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [4:0] dec_instr_type,
  input  logic [4:0] dec_src_0,
  input  logic       dec_src_0_used,
  input  logic [4:0] dec_src_1,
  input  logic       dec_src_1_used,
  input  logic [4:0] dec_dst,
  input  logic       dec_dst_used,
  input  logic       wb_write_en,
  input  logic [4:0] wb_write_reg,
  input  logic       jump_taken,
  output logic       stall,
  output logic       squash,
  output logic [5:0] pending_count,
  output logic       err_spurious_wb
);

  localparam logic [3:0] SquashLoad = 4'(SQUASH_CYCLES - 1);

  logic       w_pend_src_0;
  logic       w_pend_src_1;
  logic       w_pend_dst;
  logic       w_clr_hit;
  logic       w_hazard;
  logic       w_squash;
  logic       w_stall;
  logic       w_issue;
  logic       w_spurious;
  logic [3:0] r_squash_cnt;
  logic [3:0] w_squash_cnt_d;
  logic       r_err_spurious_wb;
  logic       w_unused;

  // Stall/squash are driven by decoded register fields only; the type code is not needed.
  assign w_unused = ^dec_instr_type;

  hazard_scoreboard #(
    .NUM_REGS_P (NUM_REGS)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .i_set_en        (w_issue),
    .i_set_reg       (dec_dst),
    .i_clr_en        (wb_write_en),
    .i_clr_reg       (wb_write_reg),
    .i_rd_reg_0      (dec_src_0),
    .i_rd_reg_1      (dec_src_1),
    .i_rd_reg_2      (dec_dst),
    .o_pend_0        (w_pend_src_0),
    .o_pend_1        (w_pend_src_1),
    .o_pend_2        (w_pend_dst),
    .o_clr_hit       (w_clr_hit),
    .o_pending_count (pending_count)
  );

  assign w_hazard = dec_valid & ((dec_src_0_used & w_pend_src_0) |
                                 (dec_src_1_used & w_pend_src_1) |
                                 (dec_dst_used   & w_pend_dst));

  assign w_squash = jump_taken | (r_squash_cnt != '0);
  assign w_stall  = w_hazard & ~w_squash;
  assign w_issue  = dec_valid & ~w_stall & ~w_squash & dec_dst_used & (dec_dst != '0);

  // A jump inside the window reloads, so the window always ends SQUASH_CYCLES after the last jump.
  always_comb begin
    w_squash_cnt_d = r_squash_cnt;
    if (jump_taken) begin
      w_squash_cnt_d = SquashLoad;
    end else if (r_squash_cnt != '0) begin
      w_squash_cnt_d = r_squash_cnt - 4'd1;
    end
  end

  assign w_spurious = wb_write_en & (wb_write_reg != '0) & ~w_clr_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_squash_cnt      <= '0;
      r_err_spurious_wb <= 1'b0;
    end else begin
      r_squash_cnt      <= w_squash_cnt_d;
      r_err_spurious_wb <= r_err_spurious_wb | w_spurious;
    end
  end

  assign stall           = w_stall & ~rst;
  assign squash          = w_squash & ~rst;
  assign err_spurious_wb = r_err_spurious_wb;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl with hand-computed expectations; honours WB_BYPASS_EN.
module tb_decode_hazard_ctrl;

`ifdef WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_instr_type;
  logic [4:0] dec_src_0;
  logic       dec_src_0_used;
  logic [4:0] dec_src_1;
  logic       dec_src_1_used;
  logic [4:0] dec_dst;
  logic       dec_dst_used;
  logic       wb_write_en;
  logic [4:0] wb_write_reg;
  logic       jump_taken;
  logic       stall;
  logic       squash;
  logic [5:0] pending_count;
  logic       err_spurious_wb;

  int n_checks;
  int n_pass;

  decode_hazard_ctrl #(
    .SQUASH_CYCLES (2),
    .NUM_REGS      (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dec_valid       (dec_valid),
    .dec_instr_type  (dec_instr_type),
    .dec_src_0       (dec_src_0),
    .dec_src_0_used  (dec_src_0_used),
    .dec_src_1       (dec_src_1),
    .dec_src_1_used  (dec_src_1_used),
    .dec_dst         (dec_dst),
    .dec_dst_used    (dec_dst_used),
    .wb_write_en     (wb_write_en),
    .wb_write_reg    (wb_write_reg),
    .jump_taken      (jump_taken),
    .stall           (stall),
    .squash          (squash),
    .pending_count   (pending_count),
    .err_spurious_wb (err_spurious_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle();
    dec_valid      = 1'b0;
    dec_instr_type = 5'd0;
    dec_src_0      = 5'd0;
    dec_src_0_used = 1'b0;
    dec_src_1      = 5'd0;
    dec_src_1_used = 1'b0;
    dec_dst        = 5'd0;
    dec_dst_used   = 1'b0;
    wb_write_en    = 1'b0;
    wb_write_reg   = 5'd0;
    jump_taken     = 1'b0;
  endtask

  // Writer of rd.
  task automatic dec_write(input logic [4:0] rd);
    idle();
    dec_valid      = 1'b1;
    dec_instr_type = 5'd4;
    dec_dst        = rd;
    dec_dst_used   = 1'b1;
  endtask

  // Reader of rs on the chosen source port, no destination.
  task automatic dec_read(input logic [4:0] rs, input bit port1);
    idle();
    dec_valid      = 1'b1;
    dec_instr_type = 5'd3;
    if (port1) begin
      dec_src_1      = rs;
      dec_src_1_used = 1'b1;
    end else begin
      dec_src_0      = rs;
      dec_src_0_used = 1'b1;
    end
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_write_en  = 1'b1;
    wb_write_reg = rd;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    jump_taken = 1'b1;
    dec_read(5'd1, 1'b0);
    jump_taken = 1'b1;
    #1;
    check("rst_squash", 32'(squash), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // RAW on r3
    @(negedge clk); rst = 1'b0; idle(); #1;
    check("init_pending", 32'(pending_count), 32'd0);
    check("init_err", 32'(err_spurious_wb), 32'd0);
    check("init_squash", 32'(squash), 32'd0);
    @(negedge clk); dec_write(5'd3); #1;
    check("w3_stall", 32'(stall), 32'd0);
    @(negedge clk); dec_read(5'd3, 1'b0); #1;
    check("w3_pending", 32'(pending_count), 32'd1);
    check("raw3_stall_a", 32'(stall), 32'd1);
    @(negedge clk); #1;
    check("raw3_stall_b", 32'(stall), 32'd1);
    @(negedge clk); wb(5'd3); #1;
    check("raw3_wb_cycle", 32'(stall), 32'(!Bypass));
    @(negedge clk); wb_write_en = 1'b0; #1;
    check("raw3_after_wb", 32'(stall), 32'd0);
    check("raw3_pending0", 32'(pending_count), 32'd0);

    // Single jump squashes a writer of r5 for two cycles
    @(negedge clk); dec_write(5'd5); jump_taken = 1'b1; #1;
    check("j1_squash_c0", 32'(squash), 32'd1);
    check("j1_stall_c0", 32'(stall), 32'd0);
    @(negedge clk); jump_taken = 1'b0; #1;
    check("j1_squash_c1", 32'(squash), 32'd1);
    @(negedge clk); dec_read(5'd5, 1'b0); #1;
    check("j1_squash_end", 32'(squash), 32'd0);
    check("j1_r5_nostall", 32'(stall), 32'd0);
    check("j1_pending", 32'(pending_count), 32'd0);

    // Back-to-back jumps extend the window; hazard on r10 masked inside it
    @(negedge clk); dec_write(5'd10); #1;
    check("w10_stall", 32'(stall), 32'd0);
    @(negedge clk); dec_read(5'd10, 1'b0); jump_taken = 1'b1; #1;
    check("w10_pending", 32'(pending_count), 32'd1);
    check("j2_squash_c0", 32'(squash), 32'd1);
    check("j2_stall_c0", 32'(stall), 32'd0);
    @(negedge clk); #1;
    check("j2_squash_c1", 32'(squash), 32'd1);
    check("j2_stall_c1", 32'(stall), 32'd0);
    @(negedge clk); jump_taken = 1'b0; #1;
    check("j2_squash_c2", 32'(squash), 32'd1);
    check("j2_stall_c2", 32'(stall), 32'd0);
    @(negedge clk); #1;
    check("j2_squash_c3", 32'(squash), 32'd0);
    check("j2_stall_c3", 32'(stall), 32'd1);
    @(negedge clk); idle(); wb(5'd10);

    // Issue to r7 against a same-cycle write-back of r7
    @(negedge clk); dec_write(5'd7); #1;
    check("w7_pending0", 32'(pending_count), 32'd0);
    check("w7_stall", 32'(stall), 32'd0);
    @(negedge clk); dec_write(5'd7); wb(5'd7); #1;
    check("w7_pending1", 32'(pending_count), 32'd1);
    check("w7_wb_stall", 32'(stall), 32'(!Bypass));
    @(negedge clk); dec_write(5'd7); #1;
    check("w7_after_pending", 32'(pending_count), 32'(Bypass));
    check("w7_after_stall", 32'(stall), 32'(Bypass));
    @(negedge clk); dec_read(5'd7, 1'b1); #1;
    check("r7_pending", 32'(pending_count), 32'd1);
    check("r7_stall", 32'(stall), 32'd1);

    // Fill the scoreboard
    @(negedge clk); idle(); wb(5'd7);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); dec_write(5'(i)); #1;
      check($sformatf("fill_stall_r%0d", i), 32'(stall), 32'd0);
    end
    @(negedge clk);
    dec_write(5'd0);
    dec_src_0_used = 1'b1;
    dec_src_1_used = 1'b1;
    #1;
    check("fill_pending31", 32'(pending_count), 32'd31);
    check("r0_stall", 32'(stall), 32'd0);
    @(negedge clk); dec_read(5'd31, 1'b0); #1;
    check("r0_pending_same", 32'(pending_count), 32'd31);
    check("r31_stall", 32'(stall), 32'd1);

    // Spurious write-back and set-wins on a non-pending register
    @(negedge clk); idle(); wb(5'd0);
    @(negedge clk); idle(); wb(5'd9); #1;
    check("wb_r0_noerr", 32'(err_spurious_wb), 32'd0);
    @(negedge clk); idle(); wb(5'd9); #1;
    check("wb9_pending30", 32'(pending_count), 32'd30);
    check("wb9_legit_noerr", 32'(err_spurious_wb), 32'd0);
    @(negedge clk); dec_write(5'd9); wb(5'd9); #1;
    check("spur_err_set", 32'(err_spurious_wb), 32'd1);
    check("setwin_stall", 32'(stall), 32'd0);
    @(negedge clk); dec_read(5'd9, 1'b0); #1;
    check("setwin_pending31", 32'(pending_count), 32'd31);
    check("setwin_r9_stall", 32'(stall), 32'd1);
    check("err_sticky_a", 32'(err_spurious_wb), 32'd1);
    repeat (3) @(negedge clk);
    idle(); #1;
    check("err_sticky_b", 32'(err_spurious_wb), 32'd1);

    // Mid-run reset
    @(negedge clk); rst = 1'b1; dec_read(5'd9, 1'b0); jump_taken = 1'b1; #1;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_squash", 32'(squash), 32'd0);
    @(negedge clk); rst = 1'b0; idle(); #1;
    check("midrst_pending", 32'(pending_count), 32'd0);
    check("midrst_err", 32'(err_spurious_wb), 32'd0);
    check("midrst_squash_after", 32'(squash), 32'd0);
    @(negedge clk); wb(5'd5);
    @(negedge clk); idle(); #1;
    check("post_rst_spur_err", 32'(err_spurious_wb), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
